// File: rtl/fixed_softplus_pkg.sv
`default_nettype none
// fixed_softplus_pkg: shared segment encoding, Q1.15 coefficients and the
// round-half-up shift used by the piecewise-quadratic softplus.
package fixed_softplus_pkg;

  localparam int COEF_FRAC = 15;

  typedef enum logic [2:0] {
    SEG_ZERO = 3'd0,
    SEG_1    = 3'd1,
    SEG_2    = 3'd2,
    SEG_3    = 3'd3,
    SEG_4    = 3'd4,
    SEG_ID   = 3'd5
  } seg_t;

  typedef logic signed [15:0] coef_t;

  // Padded to 8 entries so any 3-bit segment code indexes in range.
  localparam coef_t A2 [8] = '{16'sh0000, 16'sh030B, 16'sh0C67, 16'sh0C67,
                               16'sh030B, 16'sh0000, 16'sh0000, 16'sh0000};
  localparam coef_t A1 [8] = '{16'sh0000, 16'sh18EF, 16'sh3C68, 16'sh4397,
                               16'sh6710, 16'sh0000, 16'sh0000, 16'sh0000};
  localparam coef_t A0 [8] = '{16'sh0000, 16'sh358E, 16'sh581E, 16'sh581E,
                               16'sh358E, 16'sh0000, 16'sh0000, 16'sh0000};

  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                     input int k);
    if (k <= 0) return v;
    return (v + (64'sd1 <<< (k - 1))) >>> k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_softplus_lane.sv
`default_nettype none
// fixed_softplus_lane: one lane of the 3-stage softplus datapath; stage
// enables come from the shared handshake logic in the top level.
module fixed_softplus_lane
  import fixed_softplus_pkg::*;
#(
  parameter int W  = 16,
  parameter int F  = 8,
  parameter int WO = 16,
  parameter int FO = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en1,
  input  logic          en2,
  input  logic          en3,
  input  logic [W-1:0]  x_in,
  output logic [WO-1:0] y_out
);

  localparam int XW = W + 4;
  localparam int TW = W + 17;
  localparam logic signed [XW-1:0] POS2 = XW'(longint'(2) <<< F);
  localparam logic signed [XW-1:0] POS4 = XW'(longint'(4) <<< F);
  localparam logic signed [XW-1:0] NEG2 = -POS2;
  localparam logic signed [XW-1:0] NEG4 = -POS4;
  localparam int ID_UP = (F <= COEF_FRAC) ? COEF_FRAC - F : 0;
  localparam int ID_DN = (F >  COEF_FRAC) ? F - COEF_FRAC : 0;
  localparam logic signed [63:0] O_MAX = (64'sd1 <<< (WO - 1)) - 64'sd1;
  localparam logic signed [63:0] O_MIN = -(64'sd1 <<< (WO - 1));

  logic signed [XW-1:0] x_ext;
  seg_t                 seg_in;
  logic signed [W-1:0]  x1, x2;
  seg_t                 seg1, seg2;
  logic signed [TW-1:0] t_next, t2;
  logic signed [63:0]   y_full, o_full;
  logic [WO-1:0]        o_next, o3;

  always_comb begin
    x_ext = XW'($signed(x_in));
    if (x_ext < NEG4)       seg_in = SEG_ZERO;
    else if (x_ext < NEG2)  seg_in = SEG_1;
    else if (x_ext < 0)     seg_in = SEG_2;
    else if (x_ext < POS2)  seg_in = SEG_3;
    else if (x_ext <= POS4) seg_in = SEG_4;
    else                    seg_in = SEG_ID;
  end

  // First Horner step: t = round(a2*x / 2^F) + a1, kept in Q.15.
  always_comb begin
    t_next = TW'(round_shift(64'(A2[seg1]) * 64'(x1), F) + 64'(A1[seg1]));
  end

  always_comb begin
    case (seg2)
      SEG_ZERO: y_full = '0;
      SEG_ID:   y_full = round_shift(64'(x2) <<< ID_UP, ID_DN);
      default:  y_full = round_shift(64'(t2) * 64'(x2), F) + 64'(A0[seg2]);
    endcase
    o_full = round_shift(y_full, COEF_FRAC - FO);
    if (o_full > O_MAX)      o_next = WO'(O_MAX);
    else if (o_full < O_MIN) o_next = WO'(O_MIN);
    else                     o_next = WO'(o_full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1   <= '0;
      seg1 <= SEG_ZERO;
      x2   <= '0;
      seg2 <= SEG_ZERO;
      t2   <= '0;
      o3   <= '0;
    end else begin
      if (en1) begin
        x1   <= $signed(x_in);
        seg1 <= seg_in;
      end
      if (en2) begin
        x2   <= x1;
        seg2 <= seg1;
        t2   <= t_next;
      end
      if (en3) begin
        o3 <= o_next;
      end
    end
  end

  assign y_out = o3;

endmodule
`default_nettype wire

// File: rtl/fixed_softplus_pwq.sv
`default_nettype none
// fixed_softplus_pwq: N-lane piecewise-quadratic softplus with a shared
// 3-stage valid/ready pipeline and full backpressure.
module fixed_softplus_pwq
  import fixed_softplus_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0       = 16,
  parameter int DATA_IN_0_PRECISION_1       = 8,
  parameter int DATA_OUT_0_PRECISION_0      = 16,
  parameter int DATA_OUT_0_PRECISION_1      = 8,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 1,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int DATA_OUT_0_PARALLELISM_DIM_0 = DATA_IN_0_PARALLELISM_DIM_0,
  parameter int DATA_OUT_0_PARALLELISM_DIM_1 = DATA_IN_0_PARALLELISM_DIM_1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0],
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0],
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
);

  localparam int N = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;

  logic v1, v2, v3;
  logic load1, load2, load3;

  // Each stage advances when empty or when the stage after it advances, so
  // bubbles collapse while the output is stalled.
  always_comb begin
    load3 = !v3 || data_out_0_ready;
    load2 = !v2 || load3;
    load1 = !v1 || load2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (load1) v1 <= data_in_0_valid;
      if (load2) v2 <= v1;
      if (load3) v3 <= v2;
    end
  end

  assign data_in_0_ready  = load1;
  assign data_out_0_valid = v3;

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      fixed_softplus_lane #(
        .W  (DATA_IN_0_PRECISION_0),
        .F  (DATA_IN_0_PRECISION_1),
        .WO (DATA_OUT_0_PRECISION_0),
        .FO (DATA_OUT_0_PRECISION_1)
      ) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .en1   (load1 && data_in_0_valid),
        .en2   (load2 && v1),
        .en3   (load3 && v2),
        .x_in  (data_in_0[i]),
        .y_out (data_out_0[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fixed_softplus_pwq.sv
`timescale 1ns/1ps
// tb_fixed_softplus_pwq: randomized and directed scoreboard bench for the
// softplus block (4-lane main instance, narrow-output saturation instance).
module tb_fixed_softplus_pwq;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] din  [N-1:0];
  logic        din_valid;
  logic        din_ready;
  logic [15:0] dout [N-1:0];
  logic        dout_valid;
  logic        dout_ready;

  logic [15:0] sdin  [0:0];
  logic        sdin_valid;
  logic        sdin_ready;
  logic [7:0]  sdout [0:0];
  logic        sdout_valid;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] exp_q[$];
  logic [63:0] x_q[$];
  logic [7:0]  s_exp_q[$];
  logic [15:0] s_x_q[$];

  bit rand_ready = 0;
  bit ready_level = 1;

  fixed_softplus_pwq #(
    .DATA_IN_0_PRECISION_0(16), .DATA_IN_0_PRECISION_1(8),
    .DATA_OUT_0_PRECISION_0(16), .DATA_OUT_0_PRECISION_1(8),
    .DATA_IN_0_TENSOR_SIZE_DIM_0(2), .DATA_IN_0_TENSOR_SIZE_DIM_1(2),
    .DATA_IN_0_PARALLELISM_DIM_0(2), .DATA_IN_0_PARALLELISM_DIM_1(2),
    .DATA_OUT_0_PARALLELISM_DIM_0(2), .DATA_OUT_0_PARALLELISM_DIM_1(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(din_ready),
    .data_out_0(dout), .data_out_0_valid(dout_valid), .data_out_0_ready(dout_ready)
  );

  fixed_softplus_pwq #(
    .DATA_IN_0_PRECISION_0(16), .DATA_IN_0_PRECISION_1(8),
    .DATA_OUT_0_PRECISION_0(8), .DATA_OUT_0_PRECISION_1(4),
    .DATA_IN_0_TENSOR_SIZE_DIM_0(1), .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
    .DATA_IN_0_PARALLELISM_DIM_0(1), .DATA_IN_0_PARALLELISM_DIM_1(1),
    .DATA_OUT_0_PARALLELISM_DIM_0(1), .DATA_OUT_0_PARALLELISM_DIM_1(1)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .data_in_0(sdin), .data_in_0_valid(sdin_valid), .data_in_0_ready(sdin_ready),
    .data_out_0(sdout), .data_out_0_valid(sdout_valid), .data_out_0_ready(1'b1)
  );

  // ---------------- reference model ----------------
  function automatic longint floor_div(longint n, longint d);
    longint q = n / d;
    if ((n % d) != 0 && n < 0) q = q - 1;
    return q;
  endfunction

  // Round half up: floor((v + 2^(k-1)) / 2^k)
  function automatic longint rnd(longint v, int k);
    if (k == 0) return v;
    return floor_div(v + (longint'(1) <<< (k - 1)), longint'(1) <<< k);
  endfunction

  function automatic longint softplus_model(longint x, int f, int wo, int fo);
    longint one = longint'(1) <<< f;
    longint a2 = 0, a1 = 0, a0 = 0, t, y, o, hi, lo;
    if (x < -4 * one) y = 0;
    else if (x > 4 * one) y = x * (longint'(1) <<< (15 - f));
    else begin
      if (x < -2 * one)     begin a2 = 'h030B; a1 = 'h18EF; a0 = 'h358E; end
      else if (x < 0)       begin a2 = 'h0C67; a1 = 'h3C68; a0 = 'h581E; end
      else if (x < 2 * one) begin a2 = 'h0C67; a1 = 'h4397; a0 = 'h581E; end
      else                  begin a2 = 'h030B; a1 = 'h6710; a0 = 'h358E; end
      t = rnd(a2 * x, f) + a1;
      y = rnd(t * x, f) + a0;
    end
    o  = rnd(y, 15 - fo);
    hi = (longint'(1) <<< (wo - 1)) - 1;
    lo = -(longint'(1) <<< (wo - 1));
    if (o > hi) o = hi;
    if (o < lo) o = lo;
    return o;
  endfunction

  function automatic bit known_value(input logic [15:0] x, output logic [15:0] v);
    case (x)
      16'h0000: begin v = 16'h00B0; return 1'b1; end
      16'h0400: begin v = 16'h0405; return 1'b1; end
      16'h0500: begin v = 16'h0500; return 1'b1; end
      16'hFB00: begin v = 16'h0000; return 1'b1; end
      default:  begin v = 16'h0000; return 1'b0; end
    endcase
  endfunction

  // ---------------- ready driver ----------------
  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      dout_ready = rand_ready ? 1'($urandom_range(1)) : ready_level;
    end
  end

  // ---------------- scoreboard push + monitor ----------------
  initial begin : monitor
    logic [63:0] e, xs, got, held;
    logic [15:0] kv, xl, gl;
    logic [7:0]  se;
    logic [15:0] sx;
    real xr, sp, dv, diff;
    bit holding;
    holding = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete(); x_q.delete(); s_exp_q.delete(); s_x_q.delete();
        holding = 0;
      end else begin
        if (din_valid && din_ready) begin
          for (int l = 0; l < N; l++) begin
            e[l*16 +: 16]  = 16'(softplus_model(longint'($signed(din[l])), 8, 16, 8));
            xs[l*16 +: 16] = din[l];
          end
          exp_q.push_back(e);
          x_q.push_back(xs);
        end
        for (int l = 0; l < N; l++) got[l*16 +: 16] = dout[l];
        if (holding) begin
          vectors++;
          if (dout_valid !== 1'b1 || got !== held) begin
            miscompares++;
            $display("FAIL stall_hold valid=%b got=%h held=%h", dout_valid, got, held);
          end
        end
        if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_output got=%h", got);
          end else begin
            e  = exp_q.pop_front();
            xs = x_q.pop_front();
            for (int l = 0; l < N; l++) begin
              xl = xs[l*16 +: 16];
              gl = got[l*16 +: 16];
              vectors++;
              if (gl !== e[l*16 +: 16]) begin
                miscompares++;
                $display("FAIL model lane%0d x=%h got=%h exp=%h", l, xl, gl, e[l*16 +: 16]);
              end
              if (known_value(xl, kv)) begin
                vectors++;
                if (gl !== kv) begin
                  miscompares++;
                  $display("FAIL known lane%0d x=%h got=%h exp=%h", l, xl, gl, kv);
                end
              end
              if ($signed(xl) >= -1024 && $signed(xl) <= 1024) begin
                xr = real'($signed(xl)) / 256.0;
                sp = $ln(1.0 + $exp(xr));
                dv = real'($signed(gl)) / 256.0;
                diff = (dv > sp) ? dv - sp : sp - dv;
                vectors++;
                if (diff > 0.01 + 1.0 / 512.0) begin
                  miscompares++;
                  $display("FAIL accuracy x=%f got=%f exp=%f", xr, dv, sp);
                end
              end
            end
          end
        end
        holding = dout_valid && !dout_ready;
        held = got;

        if (sdin_valid && sdin_ready) begin
          s_exp_q.push_back(8'(softplus_model(longint'($signed(sdin[0])), 8, 8, 4)));
          s_x_q.push_back(sdin[0]);
        end
        if (sdout_valid) begin
          if (s_exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL sat_unexpected got=%h", sdout[0]);
          end else begin
            se = s_exp_q.pop_front();
            sx = s_x_q.pop_front();
            vectors++;
            if (sdout[0] !== se) begin
              miscompares++;
              $display("FAIL sat_model x=%h got=%h exp=%h", sx, sdout[0], se);
            end
            if (sx == 16'h7F00) begin
              vectors++;
              if (sdout[0] !== 8'h7F) begin
                miscompares++;
                $display("FAIL sat_max x=%h got=%h exp=7f", sx, sdout[0]);
              end
            end
            if ($signed(sx) < 0) begin
              vectors++;
              if ($signed(sdout[0]) < 0) begin
                miscompares++;
                $display("FAIL sat_nonneg x=%h got=%h exp>=0", sx, sdout[0]);
              end
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [63:0] xs, output int waits, output bit vout);
    bit ok;
    for (int l = 0; l < N; l++) din[l] = xs[l*16 +: 16];
    din_valid = 1'b1;
    waits = 0;
    ok = 0;
    vout = 0;
    do begin
      @(negedge clk);
      ok = din_ready;
      vout = dout_valid;
      waits++;
      @(posedge clk);
      #1;
    end while (!ok && waits < 1000);
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout waits=%0d", waits);
    end
    din_valid = 1'b0;
  endtask

  task automatic latency_check(input logic [63:0] xs);
    int cnt = 0;
    bit drop = 0;
    for (int l = 0; l < N; l++) din[l] = xs[l*16 +: 16];
    din_valid = 1'b1;
    @(negedge clk);
    if (!din_ready) drop = 1;
    @(posedge clk);
    #1 din_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (!din_ready) drop = 1;
      if (dout_valid && cnt == 0) cnt = i;
    end
    vectors++;
    if (cnt != 3) begin
      miscompares++;
      $display("FAIL latency got=%0d exp=3", cnt);
    end
    vectors++;
    if (drop) begin
      miscompares++;
      $display("FAIL latency_ready got=0 exp=1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || s_exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || s_exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d sat_pending=%0d exp=0", exp_q.size(), s_exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_x();
    if ($urandom_range(1)) return 16'($signed(16'($urandom_range(0, 3072))) - 16'sd1536);
    return 16'($urandom);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] xs;
    int waits;
    bit vout;
    din_valid = 1'b0;
    sdin_valid = 1'b0;
    sdin[0] = '0;
    for (int l = 0; l < N; l++) din[l] = '0;

    repeat (2) @(negedge clk);
    vectors++;
    if (dout_valid !== 1'b0 || dout[0] !== 16'h0 || dout[3] !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state valid=%b data0=%h exp valid=0 data=0", dout_valid, dout[0]);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    vectors++;
    if (din_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready got=%b exp=1", din_ready);
    end
    @(posedge clk);
    #1;

    // Known values, single beat, with latency measurement.
    latency_check({16'hFB00, 16'h0500, 16'h0400, 16'h0000});
    send({rand_x(), rand_x(), 16'h0100, 16'hFC00}, waits, vout);

    // Saturation instance.
    sdin[0] = 16'h7F00;
    sdin_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      sdin[0] = (i < 9) ? (16'h8000 | 16'($urandom_range(0, 16'h7FFF))) : 16'($urandom_range(0, 16'h7FFF));
      @(posedge clk);
      #1;
    end
    sdin_valid = 1'b0;
    drain();

    // Boundary sweep -5..5 in 1/256 steps, ready held high: 1 beat/cycle.
    for (int b = 0; b < 641; b++) begin
      for (int l = 0; l < N; l++) begin
        int xi;
        xi = -1280 + b * N + l;
        if (xi > 1280) xi = 1280;
        xs[l*16 +: 16] = 16'(xi);
      end
      send(xs, waits, vout);
      if (b >= 3) begin
        vectors++;
        if (waits != 1 || !vout) begin
          miscompares++;
          $display("FAIL throughput beat=%0d waits=%0d valid=%b exp waits=1 valid=1", b, waits, vout);
        end
      end
    end
    drain();

    // Random valid / random ready backpressure.
    rand_ready = 1;
    for (int b = 0; b < 1000; b++) begin
      if ($urandom_range(1)) begin
        @(posedge clk);
        #1;
      end
      for (int l = 0; l < N; l++) xs[l*16 +: 16] = rand_x();
      send(xs, waits, vout);
    end
    rand_ready = 0;
    ready_level = 1;
    drain();

    // Asynchronous reset with the pipe full and stalled.
    ready_level = 0;
    @(posedge clk);
    #1;
    din_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int l = 0; l < N; l++) din[l] = rand_x();
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (dout_valid !== 1'b0 || dout[0] !== 16'h0 || dout[1] !== 16'h0 ||
        dout[2] !== 16'h0 || dout[3] !== 16'h0) begin
      miscompares++;
      $display("FAIL async_reset valid=%b data=%h %h %h %h exp valid=0 data=0",
               dout_valid, dout[0], dout[1], dout[2], dout[3]);
    end
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ready_level = 1;
    #1;
    vectors++;
    if (din_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_ready got=%b exp=1", din_ready);
    end
    latency_check({rand_x(), rand_x(), rand_x(), rand_x()});
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fixed_softplus_pwq.md
# fixed_softplus_pwq

Parametrised, fully pipelined piecewise-quadratic softplus activation for the activation-layer library. It accepts N = PARALLELISM_DIM_0 × PARALLELISM_DIM_1 signed fixed-point lanes per beat, with arbitrary input and output width and fraction bits. Each lane is evaluated with a 4-segment quadratic plus zero/identity tails, and the result is rounded and saturated. All lanes share one valid/ready stream with full backpressure support and no bubbles, so the block drops into any dataflow pipeline.

## Interface
- DATA_IN_0_PRECISION_0, 16: input width W (signed)
- DATA_IN_0_PRECISION_1, 8: input fraction bits F (0 ≤ F < W)
- DATA_OUT_0_PRECISION_0, 16: output width WO (signed)
- DATA_OUT_0_PRECISION_1, 8: output fraction bits FO (0 ≤ FO ≤ 15)
- DATA_IN_0_TENSOR_SIZE_DIM_0/1, 1: informational only
- DATA_IN_0_PARALLELISM_DIM_0/1, 1: lane grid; N = product
- DATA_OUT_0_PARALLELISM_DIM_0/1: equal to the input values
- clk  in  1  sole clock
- rst_n  in  1  reset, asynchronous assert, active-low
- data_in_0  in  W × N (unpacked [N-1:0])  input lanes
- data_in_0_valid  in  1  input beat valid
- data_in_0_ready  out  1  input beat accepted when high with valid
- data_out_0  out  WO × N  result lanes
- data_out_0_valid  out  1  result valid
- data_out_0_ready  in  1  downstream accept

## Operation
- Segment select on x (real value x/2^F), with thresholds held as constants extended to W+4 bits so they are valid for any F:
  - S0: x < −4 → 0
  - S1: −4 ≤ x < −2
  - S2: −2 ≤ x < 0
  - S3: 0 ≤ x < 2
  - S4: 2 ≤ x ≤ 4
  - S5: x > 4 → x (identity)
- Coefficients are Q1.15 signed:
  - S1: (a2, a1, a0) = (0x030B, 0x18EF, 0x358E)
  - S2: (0x0C67, 0x3C68, 0x581E)
  - S3: (0x0C67, 0x4397, 0x581E)
  - S4: (0x030B, 0x6710, 0x358E)
- Horner evaluation, with every intermediate in Q.15 and widths sized so nothing overflows (t ≥ W+17 bits):
  - t = round(a2·x / 2^F) + a1
  - y = round(t·x / 2^F) + a0
- Rounding is round-half-up: add 2^(k−1), then arithmetic shift right by k.
- S0 gives y = 0. S5 gives y = x·2^(15−F), computed in a wide intermediate.
- Output conversion: o = round(y / 2^(15−FO)), saturated to [−2^(WO−1), 2^(WO−1)−1]. When 15−FO = 0, no shift is applied.
- All lanes are independent and share a single handshake.

## Timing
- 3-stage pipeline; latency is 3 cycles from input accept to valid output, with no stalls.
  - Stage 1: register x and the segment code.
  - Stage 2: register t, x and the segment code.
  - Stage 3: register o (the output register).
- Each stage k carries v_k. Stage k loads when (!v_k || load_{k+1}). Stage 3 "loads" when (!v_3 || data_out_0_ready).
- data_in_0_ready = load_1. This is combinational from data_out_0_ready and the valids only, never from data_in_0_valid.
- Throughput is 1 beat/cycle. Internal bubbles collapse while the output is stalled.
- While data_out_0_valid is high and data_out_0_ready is low, data_out_0 holds stable.
- Reset (rst_n low, asynchronous): all v_k = 0, data_out_0_valid = 0, data_out_0 = 0, data_in_0_ready = 1 once reset is released. Reset mid-stream discards all in-flight beats.
- Simultaneous accept at stage 1 and drain at stage 3 in the same cycle with a full pipe: no loss and no duplication.

## Structure
- Package fixed_softplus_pkg holds:
  - COEF_FRAC = 15
  - the segment enum (SEG_ZERO, SEG_1..SEG_4, SEG_ID)
  - coefficient arrays A2/A1/A0 indexed by segment
  - the rounding-shift function
- Sub-module fixed_softplus_lane is a single-lane 3-stage datapath with stage enables as inputs, instantiated N times. The top level owns the valid/ready control.

## Test plan
Defaults unless stated: W=16, F=8, WO=16, FO=8.
- Known values, one lane:
  - x = 0x0000 → 0x00B0
  - x = 0x0400 (4.0) → 0x0405
  - x = 0x0500 → 0x0500
  - x = 0xFB00 (−5.0) → 0x0000
  - x = 0xFC00 (−4.0) → S1 result, checked against a bit-accurate reference model
- Boundary sweep: every x in [−5, 5] in steps of 2^−8. Outputs must match a bit-exact model and be within 0.01 of ln(1+e^x) for |x| ≤ 4.
- Saturation: WO=8, FO=4, x = 0x7F00 (127.0) → 0x7F. Any negative input → never below 0.
- Backpressure, N=4 (DIM_0=2, DIM_1=2): random valid and random ready (50%) over 1000 beats. Require in-order, lossless delivery; stable output while stalled; and 1 beat/cycle once ready is held high.
- Reset: assert rst_n low asynchronously with 3 beats in flight. Outputs drop to valid=0 and data=0 immediately. After release, the first output equals the first post-reset input beat, 3 cycles later.
- Latency: a single beat with ready held high produces data_out_0_valid exactly 3 cycles after accept, with data_in_0_ready never deasserted.
